// File: rtl/uart_rx_pkt_parser.sv
// Frames UART bytes into HEADER/LEN/payload/CSUM packets, verifies them
// and streams accepted payload to the core over valid/ready.
module uart_rx_pkt_parser #(
  parameter int unsigned SYS_CLK       = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_d,
  input  logic       i_rx_complete,
  input  logic       i_rx_error,
  output logic [7:0] o_pl_d,
  output logic       o_pl_valid,
  input  logic       i_pl_ready,
  output logic       o_pl_last,
  output logic       o_pkt_ok,
  output logic       o_pkt_err,
  output logic [1:0] o_err_code,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam int unsigned TIMEOUT_CYC =
    (SYS_CLK / BAUD_RATE) * 10 * TIMEOUT_BYTES;
  localparam int unsigned TW =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_B   = 8'(MAX_LEN);

  localparam logic [1:0] E_LEN  = 2'd0;
  localparam logic [1:0] E_CSUM = 2'd1;
  localparam logic [1:0] E_TIME = 2'd2;
  localparam logic [1:0] E_LINE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_t;

  state_t        state, state_n;
  logic          cmp_q, cmp_qq, rxe_q;
  logic [7:0]    rxd_q;
  logic          ev;
  logic [7:0]    mem [MAX_LEN];
  logic [LW-1:0] len, len_n;
  logic [LW-1:0] wr_idx, wr_idx_n;
  logic [LW-1:0] rd_idx, rd_idx_n;
  logic [7:0]    sum, sum_n, csum;
  logic [TW-1:0] tmr;
  logic          active, timed_out, hs, wr_en;
  logic          valid_n, ok_n, err_n, ovr_n;
  logic [1:0]    code_n;

  // Data and error are captured on the same edge as the strobe,
  // so the byte event sees a consistent triple.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q  <= 1'b0;
      cmp_qq <= 1'b0;
      rxd_q  <= 8'h00;
      rxe_q  <= 1'b0;
    end else begin
      cmp_q  <= i_rx_complete;
      cmp_qq <= cmp_q;
      rxd_q  <= i_rx_d;
      rxe_q  <= i_rx_error;
    end
  end

  assign ev = cmp_q & ~cmp_qq;

  assign active = (state == LEN) ||
                  (state == PAYLOAD) ||
                  (state == CSUM);

  assign timed_out = active & ~ev & (tmr == TO_LAST);
  assign hs        = o_pl_valid & i_pl_ready;
  assign csum      = sum + rxd_q;

  assign o_pl_last = o_pl_valid & (rd_idx == len - LW'(1));
  assign o_pl_d    = o_pl_valid ? mem[rd_idx[IW-1:0]] : 8'h00;
  assign o_busy    = (state != IDLE);

  always_comb begin
    state_n  = state;
    len_n    = len;
    wr_idx_n = wr_idx;
    rd_idx_n = rd_idx;
    sum_n    = sum;
    wr_en    = 1'b0;
    valid_n  = o_pl_valid;
    ok_n     = 1'b0;
    err_n    = 1'b0;
    ovr_n    = 1'b0;
    code_n   = o_err_code;
    if (active && ev && rxe_q) begin
      err_n   = 1'b1;
      code_n  = E_LINE;
      state_n = IDLE;
    end else if (timed_out) begin
      err_n   = 1'b1;
      code_n  = E_TIME;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (ev && !rxe_q && rxd_q == HEADER) begin
            sum_n   = 8'h00;
            state_n = LEN;
          end
        end
        LEN: begin
          if (ev) begin
            if (rxd_q == 8'h00 || rxd_q > MAX_B) begin
              err_n   = 1'b1;
              code_n  = E_LEN;
              state_n = IDLE;
            end else begin
              len_n    = rxd_q[LW-1:0];
              sum_n    = rxd_q;
              wr_idx_n = '0;
              state_n  = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (ev) begin
            wr_en    = 1'b1;
            sum_n    = csum;
            wr_idx_n = wr_idx + LW'(1);
            if (wr_idx_n == len) begin
              state_n = CSUM;
            end
          end
        end
        CSUM: begin
          if (ev) begin
            if (csum == 8'h00) begin
              ok_n     = 1'b1;
              rd_idx_n = '0;
              state_n  = DRAIN;
            end else begin
              err_n   = 1'b1;
              code_n  = E_CSUM;
              state_n = IDLE;
            end
          end
        end
        DRAIN: begin
          // Valid rises one cycle after the ok pulse.
          valid_n = 1'b1;
          ovr_n   = ev;
          if (hs) begin
            rd_idx_n = rd_idx + LW'(1);
            if (o_pl_last) begin
              valid_n = 1'b0;
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len        <= '0;
      wr_idx     <= '0;
      rd_idx     <= '0;
      sum        <= 8'h00;
      tmr        <= '0;
      o_pl_valid <= 1'b0;
      o_pkt_ok   <= 1'b0;
      o_pkt_err  <= 1'b0;
      o_err_code <= 2'd0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      wr_idx     <= wr_idx_n;
      rd_idx     <= rd_idx_n;
      sum        <= sum_n;
      o_pl_valid <= valid_n;
      o_pkt_ok   <= ok_n;
      o_pkt_err  <= err_n;
      o_err_code <= code_n;
      o_overrun  <= ovr_n;
      if (ev || !active) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[wr_idx[IW-1:0]] <= rxd_q;
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Directed bench for uart_rx_pkt_parser: packet-level model plus
// a per-cycle compare process and literal pins.
module tb_uart_rx_pkt_parser;

  localparam int         MAXL = 16;
  localparam logic [7:0] HDR  = 8'hA5;

  typedef struct packed {
    logic       is_err;
    logic [1:0] code;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i_rx_d;
  logic       i_rx_complete;
  logic       i_rx_error;
  logic [7:0] o_pl_d;
  logic       o_pl_valid;
  logic       i_pl_ready;
  logic       o_pl_last;
  logic       o_pkt_ok;
  logic       o_pkt_err;
  logic [1:0] o_err_code;
  logic       o_overrun;
  logic       o_busy;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         ev_cyc = 0;
  int         err_cyc = 0;
  int         got_ovr = 0;
  int         rmode = 1;
  ctl_t       ctl_q[$];
  logic [8:0] dat_q[$];
  logic [8:0] got_d[$];
  int         hs_cyc[$];
  logic [1:0] exp_code = 2'd0;
  logic [7:0] s[$];

  always #5 clk = ~clk;

  uart_rx_pkt_parser #(
    .SYS_CLK      (1000000),
    .BAUD_RATE    (100000),
    .HEADER       (8'hA5),
    .MAX_LEN      (16),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_d       (i_rx_d),
    .i_rx_complete(i_rx_complete),
    .i_rx_error   (i_rx_error),
    .o_pl_d       (o_pl_d),
    .o_pl_valid   (o_pl_valid),
    .i_pl_ready   (i_pl_ready),
    .o_pl_last    (o_pl_last),
    .o_pkt_ok     (o_pkt_ok),
    .o_pkt_err    (o_pkt_err),
    .o_err_code   (o_err_code),
    .o_overrun    (o_overrun),
    .o_busy       (o_busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Packet-level expectation: scan for HEADER, judge LEN, sum everything.
  task automatic model_stream(input logic [7:0] q[$]);
    int i = 0;
    int n;
    logic [7:0] acc;
    while (i < q.size()) begin
      if (q[i] != HDR) begin
        i++;
        continue;
      end
      if (i + 1 >= q.size()) break;
      n = int'(q[i+1]);
      if (n == 0 || n > MAXL) begin
        ctl_q.push_back('{1'b1, 2'd0});
        i += 2;
        continue;
      end
      if (i + 2 + n >= q.size()) break;
      acc = q[i+1];
      for (int k = 0; k <= n; k++) acc = acc + q[i+2+k];
      if (acc == 8'h00) begin
        ctl_q.push_back('{1'b0, 2'd0});
        for (int k = 0; k < n; k++)
          dat_q.push_back({(k == n - 1), q[i+2+k]});
      end else begin
        ctl_q.push_back('{1'b1, 2'd1});
      end
      i += 3 + n;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(negedge clk);
    i_rx_d        = b;
    i_rx_error    = e;
    i_rx_complete = 1'b1;
    @(negedge clk);
    i_rx_complete = 1'b0;
    i_rx_error    = 1'b0;
    ev_cyc        = cyc + 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [7:0] q[$]);
    model_stream(q);
    foreach (q[i]) send_byte(q[i], 1'b0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (o_busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic wait_valid(input int bound);
    int n = 0;
    while (!o_pl_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("reach_valid", 32'(o_pl_valid), 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    i_pl_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rmode == 0) i_pl_ready = 1'b0;
      else if (rmode == 1) i_pl_ready = 1'b1;
      else i_pl_ready = ~i_pl_ready;
    end
  end

  // Per-cycle compare against the expectation queues.
  initial begin
    ctl_t       e;
    logic [8:0] d;
    logic       prev_ok = 1'b0;
    logic       prev_hold = 1'b0;
    logic [9:0] prev_vec = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ok   = 1'b0;
        prev_hold = 1'b0;
        exp_code  = 2'd0;
      end else begin
        if (o_pkt_ok || o_pkt_err) begin
          chk("ok_err_excl", 32'(o_pkt_ok & o_pkt_err), 32'd0);
          if (o_pkt_err) err_cyc = cyc;
          if (ctl_q.size() == 0) begin
            chk("spurious_pkt_event", 32'({o_pkt_ok, o_pkt_err}), 32'd0);
          end else begin
            e = ctl_q.pop_front();
            chk("pkt_kind", 32'(o_pkt_err), 32'(e.is_err));
            if (e.is_err) begin
              exp_code = e.code;
              chk("err_code", 32'(o_err_code), 32'(e.code));
            end
          end
        end else begin
          chk("err_code_hold", 32'(o_err_code), 32'(exp_code));
        end
        if (prev_ok) chk("valid_after_ok", 32'(o_pl_valid), 32'd1);
        if (o_pkt_ok) chk("no_valid_with_ok", 32'(o_pl_valid), 32'd0);
        prev_ok = o_pkt_ok;
        if (prev_hold)
          chk("hold_stable", 32'({o_pl_valid, o_pl_last, o_pl_d}),
              32'(prev_vec));
        prev_hold = o_pl_valid & ~i_pl_ready;
        prev_vec  = {o_pl_valid, o_pl_last, o_pl_d};
        if (o_overrun) got_ovr++;
        if (o_pl_valid && i_pl_ready) begin
          got_d.push_back({o_pl_last, o_pl_d});
          hs_cyc.push_back(cyc);
          if (dat_q.size() == 0) begin
            chk("spurious_payload", 32'({o_pl_last, o_pl_d}), 32'h1ff);
          end else begin
            d = dat_q.pop_front();
            chk("payload", 32'({o_pl_last, o_pl_d}), 32'(d));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    i_rx_d        = 8'h00;
    i_rx_complete = 1'b0;
    i_rx_error    = 1'b0;
    rmode         = 1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(o_pl_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pulses", 32'({o_pkt_ok, o_pkt_err, o_overrun}), 32'd0);
    chk("rst_code", 32'(o_err_code), 32'd0);
    chk("rst_data", 32'({o_pl_last, o_pl_d}), 32'd0);
    rst = 1'b0;

    // good 2-byte packet, ready always high
    got_d.delete();
    hs_cyc.delete();
    s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
    run(s);
    wait_idle(50);
    chk("t1_count", 32'(got_d.size()), 32'd2);
    if (got_d.size() == 2) begin
      chk("t1_b0", 32'(got_d[0]), 32'h010);
      chk("t1_b1", 32'(got_d[1]), 32'h120);
      chk("t1_back2back", 32'(hs_cyc[1] - hs_cyc[0]), 32'd1);
    end

    // bad checksum, then a good packet
    s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCF};
    run(s);
    repeat (5) @(negedge clk);
    chk("t2_idle", 32'(o_busy), 32'd0);
    chk("t2_code", 32'(o_err_code), 32'd1);
    s = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    run(s);
    wait_idle(50);

    // garbage and bad lengths
    s = '{8'h55, 8'h33, 8'hA5, 8'h00, 8'hA5, 8'h11};
    run(s);
    repeat (5) @(negedge clk);
    chk("t3_code", 32'(o_err_code), 32'd0);
    chk("t3_idle", 32'(o_busy), 32'd0);

    // timeout
    err_cyc = 0;
    ctl_q.push_back('{1'b1, 2'd2});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (420) @(negedge clk);
    chk("t4_latency", 32'(err_cyc - ev_cyc), 32'd400);
    chk("t4_code", 32'(o_err_code), 32'd2);
    chk("t4_idle", 32'(o_busy), 32'd0);

    // stalled drain, overrun, toggled ready
    rmode = 0;
    got_d.delete();
    s = '{8'hA5, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'hDC};
    run(s);
    wait_valid(50);
    send_byte(8'hA5, 1'b0);
    chk("t5_still_valid", 32'({o_pl_valid, o_pl_d}), 32'h10A);
    rmode = 2;
    wait_idle(50);
    chk("t5_count", 32'(got_d.size()), 32'd3);
    if (got_d.size() == 3)
      chk("t5_last", 32'(got_d[2]), 32'h10C);
    rmode = 1;
    ctl_q.push_back('{1'b1, 2'd3});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h33, 1'b1);
    repeat (3) @(negedge clk);
    chk("t5_code", 32'(o_err_code), 32'd3);
    chk("t5_idle", 32'(o_busy), 32'd0);

    // reset mid-payload
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h11, 1'b0);
    chk("t6_busy_mid", 32'(o_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // reset mid-drain
    rmode = 0;
    s = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h99};
    run(s);
    wait_valid(50);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_out",
        32'({o_pl_valid, o_pl_last, o_pl_d, o_busy,
             o_pkt_ok, o_pkt_err, o_overrun, o_err_code}), 32'd0);
    dat_q.delete();
    @(negedge clk);
    rst   = 1'b0;
    rmode = 1;
    got_d.delete();
    s = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    run(s);
    wait_idle(50);
    chk("t6_count", 32'(got_d.size()), 32'd1);
    if (got_d.size() == 1)
      chk("t6_byte", 32'(got_d[0]), 32'h17F);

    repeat (5) @(negedge clk);
    chk("ctl_q_empty", 32'(ctl_q.size()), 32'd0);
    chk("dat_q_empty", 32'(dat_q.size()), 32'd0);
    chk("overrun_count", 32'(got_ovr), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
